// File: rtl/morph3x3_stream.sv
// rtl/morph3x3_stream.sv - streaming 3x3 grey-level erosion/dilation with internal line buffers
module morph3x3_stream #(
    parameter int DW    = 8,
    parameter int IMG_W = 640
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vs,
    input  logic          in_de,
    input  logic [DW-1:0] in_data,
    input  logic          mode,
    input  logic          bypass,
    output logic          out_de,
    output logic [DW-1:0] out_data,
    output logic          out_vs
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);

    logic [CW-1:0] col;
    logic [1:0]    row;
    logic          mode_r;
    logic          bypass_r;

    logic [DW-1:0] line1 [IMG_W];
    logic [DW-1:0] line2 [IMG_W];

    // Per-row history of the two previous columns: [0] = c-1, [1] = c-2
    logic [1:0][DW-1:0] h_top;
    logic [1:0][DW-1:0] h_mid;
    logic [1:0][DW-1:0] h_bot;

    logic [CW-1:0] eff_col;
    logic [1:0]    eff_row;
    logic          eff_mode;
    logic          eff_byp;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] neutral;
    logic [2:0]    rmask;
    logic [2:0]    cmask;

    logic [2:0][2:0][DW-1:0] raw;
    logic [2:0][2:0][DW-1:0] win;

    logic                    s1_de;
    logic [2:0][2:0][DW-1:0] s1_win;
    logic                    s1_mode;
    logic                    s1_byp;
    logic [DW-1:0]           s1_pix;

    logic                    s2_de;
    logic [2:0][DW-1:0]      s2_row;
    logic                    s2_mode;
    logic                    s2_byp;
    logic [DW-1:0]           s2_pix;

    logic [2:0]              vs_d;

    function automatic logic [DW-1:0] pick(input logic mx, input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
        if (mx) return (a > b) ? a : b;
        else    return (a < b) ? a : b;
    endfunction

    // A frame start in the same cycle as a pixel makes that pixel (0,0) under the new settings
    always_comb begin
        eff_col  = in_vs ? '0 : col;
        eff_row  = in_vs ? 2'd0 : row;
        eff_mode = in_vs ? mode : mode_r;
        eff_byp  = in_vs ? bypass : bypass_r;
        rd1      = line1[eff_col];
        rd2      = line2[eff_col];
        neutral  = eff_mode ? '0 : '1;
        rmask    = {1'b0, (eff_row == 2'd0), (eff_row < 2'd2)};
        cmask    = {1'b0, (eff_col == '0), (eff_col < CW'(2))};
    end

    always_comb begin
        raw[0] = {rd2, h_top[0], h_top[1]};
        raw[1] = {rd1, h_mid[0], h_mid[1]};
        raw[2] = {in_data, h_bot[0], h_bot[1]};
        for (int rr = 0; rr < 3; rr++) begin
            for (int k = 0; k < 3; k++) begin
                win[rr][k] = (rmask[rr] || cmask[k]) ? neutral : raw[rr][k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= 2'd0;
            mode_r   <= 1'b0;
            bypass_r <= 1'b0;
        end else begin
            if (in_vs) begin
                mode_r   <= mode;
                bypass_r <= bypass;
            end
            if (in_de) begin
                if (eff_col == COL_MAX) begin
                    col <= '0;
                    row <= (eff_row == 2'd2) ? 2'd2 : eff_row + 2'd1;
                end else begin
                    col <= eff_col + 1'b1;
                    row <= eff_row;
                end
            end else if (in_vs) begin
                col <= '0;
                row <= 2'd0;
            end
        end
    end

    // Line buffers and column history are never cleared; masking hides stale contents
    always_ff @(posedge clk) begin
        if (in_de) begin
            line1[eff_col] <= in_data;
            line2[eff_col] <= rd1;
            h_top          <= {h_top[0], rd2};
            h_mid          <= {h_mid[0], rd1};
            h_bot          <= {h_bot[0], in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_de   <= 1'b0;
            s1_win  <= '0;
            s1_mode <= 1'b0;
            s1_byp  <= 1'b0;
            s1_pix  <= '0;
            s2_de   <= 1'b0;
            s2_row  <= '0;
            s2_mode <= 1'b0;
            s2_byp  <= 1'b0;
            s2_pix  <= '0;
            out_de   <= 1'b0;
            out_data <= '0;
            vs_d     <= 3'b000;
        end else begin
            s1_de   <= in_de;
            s1_win  <= win;
            s1_mode <= eff_mode;
            s1_byp  <= eff_byp;
            s1_pix  <= in_data;

            s2_de   <= s1_de;
            s2_mode <= s1_mode;
            s2_byp  <= s1_byp;
            s2_pix  <= s1_pix;
            for (int rr = 0; rr < 3; rr++) begin
                s2_row[rr] <= pick(s1_mode, pick(s1_mode, s1_win[rr][0], s1_win[rr][1]),
                                   s1_win[rr][2]);
            end

            out_de <= s2_de;
            if (!s2_de)
                out_data <= '0;
            else if (s2_byp)
                out_data <= s2_pix;
            else
                out_data <= pick(s2_mode, pick(s2_mode, s2_row[0], s2_row[1]), s2_row[2]);

            vs_d <= {vs_d[1:0], in_vs};
        end
    end

    assign out_vs = vs_d[2];

endmodule

// File: tb/tb_morph3x3_stream.sv
// tb/tb_morph3x3_stream.sv - directed self-checking bench for morph3x3_stream
module tb_morph3x3_stream;

    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int LINES = 4;
    localparam int NPIX  = IMG_W * LINES;

    logic          clk;
    logic          rst_n;
    logic          in_vs;
    logic          in_de;
    logic [DW-1:0] in_data;
    logic          mode;
    logic          bypass;
    logic          out_de;
    logic [DW-1:0] out_data;
    logic          out_vs;

    int nvec;
    int nerr;
    int gate_err;
    int q[$];

    morph3x3_stream #(.DW(DW), .IMG_W(IMG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vs    (in_vs),
        .in_de    (in_de),
        .in_data  (in_data),
        .mode     (mode),
        .bypass   (bypass),
        .out_de   (out_de),
        .out_data (out_data),
        .out_vs   (out_vs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Collect valid outputs; note any nonzero data on idle cycles
    always @(negedge clk) begin
        if (out_de)
            q.push_back(int'(out_data));
        else if (out_data !== '0)
            gate_err = gate_err + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pattern / expected-output tables, hand-derived from the window geometry
    function automatic int pix(input int pat, input int r, input int c);
        case (pat)
            0:       return (r == 2 && c == 3) ? 10 : 200;
            1:       return (r == 1 && c == 1) ? 255 : 0;
            2:       return r * 16 + c + 1;
            3:       return 50;
            default: return 0;
        endcase
    endfunction

    function automatic int expv(input int pat, input int r, input int c);
        case (pat)
            0:       return (r >= 2 && r <= 3 && c >= 3 && c <= 5) ? 10 : 200;
            1:       return (r >= 1 && r <= 3 && c >= 1 && c <= 3) ? 255 : 0;
            2:       return r * 16 + c + 1;
            3:       return 50;
            default: return 0;
        endcase
    endfunction

    task automatic run_frame(input int pat, input logic m, input logic b, input int gap_pct,
                             input bit with_vs, input int toggle_at, input int npix);
        q.delete();
        if (with_vs) begin
            in_vs  = 1'b1;
            mode   = m;
            bypass = b;
            tick();
            in_vs = 1'b0;
        end
        for (int i = 0; i < npix; i++) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 99) < gap_pct) tick();
            end
            in_de   = 1'b1;
            in_data = DW'(pix(pat, i / IMG_W, i % IMG_W));
            tick();
            in_de = 1'b0;
            if (i == toggle_at) begin
                mode   = ~mode;
                bypass = ~bypass;
            end
        end
        for (int k = 0; k < 5; k++) tick();
    endtask

    task automatic check_frame(input string tag, input int pat);
        chk({tag, "_count"}, q.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            chk($sformatf("%s_r%0d_c%0d", tag, i / IMG_W, i % IMG_W),
                (i < q.size()) ? q[i] : -1, expv(pat, i / IMG_W, i % IMG_W));
        end
    endtask

    task automatic latency_probe(input logic m, input int val, input string tag);
        logic [3:0] de_h;
        logic [3:0] vs_h;
        int         dat;
        in_vs   = 1'b1;
        in_de   = 1'b1;
        mode    = m;
        in_data = DW'(val);
        de_h    = '0;
        vs_h    = '0;
        dat     = -1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            de_h[k] = out_de;
            vs_h[k] = out_vs;
            if (k == 3) dat = int'(out_data);
            tick();
            if (k == 0) begin
                in_vs = 1'b0;
                in_de = 1'b0;
            end
        end
        chk({tag, "_de_timing"}, int'(de_h), 8);
        chk({tag, "_vs_timing"}, int'(vs_h), 8);
        chk({tag, "_data"}, dat, val);
        for (int k = 0; k < 3; k++) tick();
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        gate_err = 0;
        rst_n    = 1'b0;
        in_vs    = 1'b0;
        in_de    = 1'b0;
        in_data  = '0;
        mode     = 1'b0;
        bypass   = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        @(negedge clk);
        chk("reset_out_de", int'(out_de), 0);
        chk("reset_out_data", int'(out_data), 0);
        chk("reset_out_vs", int'(out_vs), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Isolated pixel arriving with frame start: single-tap window returns the pixel itself
        latency_probe(1'b0, 90, "lat_ero");
        latency_probe(1'b1, 33, "lat_dil");

        run_frame(0, 1'b0, 1'b0, 0, 1'b1, -1, NPIX);
        check_frame("erosion_point", 0);

        run_frame(0, 1'b0, 1'b0, 30, 1'b1, -1, NPIX);
        check_frame("erosion_stall", 0);

        run_frame(1, 1'b1, 1'b0, 0, 1'b1, -1, NPIX);
        check_frame("dilation_point", 1);

        run_frame(0, 1'b0, 1'b0, 0, 1'b1, 10, NPIX);
        check_frame("mode_toggle_midframe", 0);
        run_frame(1, 1'b1, 1'b0, 0, 1'b1, -1, NPIX);
        check_frame("mode_next_frame", 1);
        run_frame(2, 1'b0, 1'b1, 0, 1'b1, 12, NPIX);
        check_frame("bypass", 2);

        // Abort a frame in line 2 with a one-cycle reset while a pixel is offered
        run_frame(0, 1'b0, 1'b0, 0, 1'b1, -1, 20);
        in_de   = 1'b1;
        in_data = 8'd10;
        rst_n   = 1'b0;
        tick();
        rst_n = 1'b1;
        in_de = 1'b0;
        @(negedge clk);
        chk("midreset_out_de", int'(out_de), 0);
        chk("midreset_out_data", int'(out_data), 0);
        chk("midreset_out_vs", int'(out_vs), 0);
        q.delete();
        for (int k = 0; k < 5; k++) tick();
        chk("midreset_dropped", q.size(), 0);

        run_frame(3, 1'b0, 1'b0, 0, 1'b0, -1, NPIX);
        check_frame("after_reset_no_vs", 3);
        run_frame(4, 1'b0, 1'b0, 0, 1'b1, -1, NPIX);
        check_frame("zero_frame", 4);
        run_frame(3, 1'b0, 1'b0, 0, 1'b1, -1, NPIX);
        check_frame("fifty_frame", 3);

        chk("idle_gating", gate_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
